// File: rtl/bpd_pkg.sv
// bpd_pkg: shared types and helpers for the bpd1 tournament predictor.
//   ckpt_t         - checkpoint queue entry {ghr, gpred, lpred}; ghr is stored
//                    zero-extended to GHR_MAX bits, so GHR_W must stay below GHR_MAX
//   init_state_t   - init sweep FSM states
//   cnt_init()     - weakly-not-taken init value for a counter of a given width
//   cnt_sat()      - saturating increment/decrement for a counter of a given width
package bpd_pkg;

    localparam int GHR_MAX = 32;
    localparam int CNT_MAX = 8;

    typedef struct packed {
        logic [GHR_MAX-1:0] ghr;
        logic               gpred;
        logic               lpred;
    } ckpt_t;

    typedef enum logic {
        ST_SWEEP,
        ST_RUN
    } init_state_t;

    function automatic logic [CNT_MAX-1:0] cnt_init(input int width);
        return CNT_MAX'((1 << (width - 1)) - 1);
    endfunction

    function automatic logic [CNT_MAX-1:0] cnt_sat(input logic [CNT_MAX-1:0] cnt,
                                                   input int width,
                                                   input logic up);
        logic [CNT_MAX-1:0] top;
        top = CNT_MAX'((1 << width) - 1);
        if (up) begin
            return (cnt == top) ? cnt : cnt + CNT_MAX'(1);
        end
        return (cnt == '0) ? cnt : cnt - CNT_MAX'(1);
    endfunction

endpackage

// File: rtl/bpd_pht.sv
// bpd_pht: table of saturating counters.
//   clock     - write clock
//   rd_idx    - combinational read index
//   rd_pred   - MSB of the counter at rd_idx (old value during a same-cycle write)
//   upd_en    - saturating update of the counter at upd_idx
//   upd_idx   - update index
//   upd_up    - 1 = count up, 0 = count down
//   init_en   - write the init value at init_idx (wins over an update)
//   init_idx  - init write index
// The array carries no reset; the owner sweeps it with the init port.
module bpd_pht
    import bpd_pkg::*;
#(
    parameter  int ENTRIES = 4096,
    parameter  int CNT_W   = 2,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clock,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_pred,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_up,
    input  logic             init_en,
    input  logic [IDX_W-1:0] init_idx
);

    logic [CNT_W-1:0] mem [ENTRIES];
    logic [CNT_W-1:0] upd_old;
    logic [CNT_W-1:0] upd_new;

    assign rd_pred = mem[rd_idx][CNT_W-1];
    assign upd_old = mem[upd_idx];
    assign upd_new = CNT_W'(cnt_sat(CNT_MAX'(upd_old), CNT_W, upd_up));

    // Read-modify-write update; the write lands on the edge, so any read in
    // the same cycle still sees the old counter.
    always_ff @(posedge clock) begin
        if (init_en) begin
            mem[init_idx] <= CNT_W'(cnt_init(CNT_W));
        end else if (upd_en) begin
            mem[upd_idx] <= upd_new;
        end
    end

endmodule

// File: rtl/bpd1.sv
// bpd1: tournament (gshare + local + choice) branch direction predictor for F1.
//   clock, reset_n              - clock, asynchronous active-low reset
//   pred_valid_i, pred_cond_i   - F1 slot valid / slot is a conditional branch
//   pred_pc_i, pred_lochist_i   - branch PC and its local history
//   btb_dir_i, pc_t_i, pc_nt_i  - BTB direction, taken / not-taken targets
//   pred_dir_o, pred_tag_o      - final direction, checkpoint tag for this branch
//   pred_stall_o                - cannot accept a conditional branch
//   override_o, override_pc_o   - redirect F1 and its target
//   rt_valid_i, rt_dir_i, rt_pc_i, rt_lochist_i - oldest branch retires (training)
//   flush_i, flush_tag_i, flush_dir_i           - mispredict recovery
module bpd1
    import bpd_pkg::*;
#(
    parameter  int GHR_W      = 12,
    parameter  int LHIST_W    = 10,
    parameter  int GCNT_W     = 2,
    parameter  int LCNT_W     = 3,
    parameter  int CCNT_W     = 2,
    parameter  int CKPT_DEPTH = 8,
    localparam int TAG_W      = $clog2(CKPT_DEPTH)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               pred_valid_i,
    input  logic               pred_cond_i,
    input  logic [63:0]        pred_pc_i,
    input  logic [LHIST_W-1:0] pred_lochist_i,
    input  logic               btb_dir_i,
    input  logic [63:0]        pc_t_i,
    input  logic [63:0]        pc_nt_i,
    output logic               pred_dir_o,
    output logic [TAG_W-1:0]   pred_tag_o,
    output logic               pred_stall_o,
    output logic               override_o,
    output logic [63:0]        override_pc_o,
    input  logic               rt_valid_i,
    input  logic               rt_dir_i,
    input  logic [63:0]        rt_pc_i,
    input  logic [LHIST_W-1:0] rt_lochist_i,
    input  logic               flush_i,
    input  logic [TAG_W-1:0]   flush_tag_i,
    input  logic               flush_dir_i
);

    localparam int INIT_W    = (GHR_W > LHIST_W) ? GHR_W : LHIST_W;
    localparam int G_ENTRIES = 1 << GHR_W;
    localparam int L_ENTRIES = 1 << LHIST_W;
    localparam logic [INIT_W-1:0] INIT_LAST = '1;

    init_state_t       state;
    init_state_t       state_next;
    logic              busy;
    logic [INIT_W-1:0] init_cnt;
    logic              init_g;
    logic              init_l;

    logic [GHR_W-1:0]  ghr;
    ckpt_t             ckpt [CKPT_DEPTH];
    logic [TAG_W-1:0]  head;
    logic [TAG_W-1:0]  tail;
    logic [TAG_W:0]    count;
    logic [TAG_W-1:0]  head_next;
    logic [TAG_W-1:0]  tail_fl;

    logic [GHR_W-1:0]  pred_pc_idx;
    logic [GHR_W-1:0]  gsh_rd_idx;
    logic [GHR_W-1:0]  rt_pc_idx;
    logic [GHR_W-1:0]  gsh_upd_idx;
    logic              gpred;
    logic              lpred;
    logic              sel_g;
    logic              accept;
    logic              do_rt;
    logic              do_fl;
    logic              cho_upd_en;
    logic              cho_up;
    logic              unused_bits;

    // Init sweep FSM: state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_SWEEP;
        end else begin
            state <= state_next;
        end
    end

    // Init sweep FSM: leave the sweep once the last index has been written.
    always_comb begin
        state_next = state;
        case (state)
            ST_SWEEP: if (init_cnt == INIT_LAST) state_next = ST_RUN;
            ST_RUN:   state_next = ST_RUN;
        endcase
    end

    // Init sweep FSM: outputs.
    always_comb begin
        busy = (state == ST_SWEEP);
    end

    // Sweep index; every table takes one entry per cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            init_cnt <= '0;
        end else if (busy) begin
            init_cnt <= init_cnt + INIT_W'(1);
        end
    end

    // The smaller table is skipped once the sweep index passes its size.
    assign init_g = busy & ({1'b0, init_cnt} < (INIT_W+1)'(G_ENTRIES));
    assign init_l = busy & ({1'b0, init_cnt} < (INIT_W+1)'(L_ENTRIES));

    assign pred_pc_idx = pred_pc_i[GHR_W+1:2];
    assign gsh_rd_idx  = pred_pc_idx ^ ghr;
    assign rt_pc_idx   = rt_pc_i[GHR_W+1:2];
    assign gsh_upd_idx = rt_pc_idx ^ ckpt[head].ghr[GHR_W-1:0];

    assign unused_bits = ^{pred_pc_i[63:GHR_W+2], pred_pc_i[1:0],
                           rt_pc_i[63:GHR_W+2], rt_pc_i[1:0],
                           ckpt[head].ghr[GHR_MAX-1:GHR_W]};

    assign pred_stall_o  = busy | (count == (TAG_W+1)'(CKPT_DEPTH));
    assign pred_dir_o    = ~busy & (sel_g ? gpred : lpred);
    assign accept        = pred_valid_i & pred_cond_i & ~pred_stall_o & ~flush_i;
    assign override_o    = accept & (btb_dir_i ^ pred_dir_o);
    assign override_pc_o = pred_dir_o ? pc_t_i : pc_nt_i;
    assign pred_tag_o    = tail;

    // Retire on an empty queue and any retire/flush during the sweep are dropped.
    assign do_rt = rt_valid_i & ~busy & (count != '0);
    assign do_fl = flush_i & ~busy;

    // The chooser only learns when the two components disagreed.
    assign cho_upd_en = do_rt & (ckpt[head].gpred ^ ckpt[head].lpred);
    assign cho_up     = (ckpt[head].gpred == rt_dir_i);

    assign head_next = do_rt ? head + TAG_W'(1) : head;
    assign tail_fl   = flush_tag_i + TAG_W'(1);

    // Queue pointers. A flush keeps the flushed branch and recomputes the
    // occupancy against the post-pop head, so retiring and flushing the head
    // together empties the queue.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head <= head_next;
            if (do_fl) begin
                tail  <= tail_fl;
                count <= {1'b0, TAG_W'(tail_fl - head_next)};
            end else if (accept) begin
                tail  <= tail + TAG_W'(1);
                count <= do_rt ? count : count + (TAG_W+1)'(1);
            end else if (do_rt) begin
                count <= count - (TAG_W+1)'(1);
            end
        end
    end

    // Checkpoint storage: snapshot of the history and both component predictions.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CKPT_DEPTH; i++) begin
                ckpt[i] <= '0;
            end
        end else if (accept) begin
            ckpt[tail] <= '{ghr: GHR_MAX'(ghr), gpred: gpred, lpred: lpred};
        end
    end

    // Speculative global history; a flush rebuilds it from the checkpoint
    // with the corrected direction shifted in.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ghr <= '0;
        end else if (do_fl) begin
            ghr <= {ckpt[flush_tag_i].ghr[GHR_W-2:0], flush_dir_i};
        end else if (accept) begin
            ghr <= {ghr[GHR_W-2:0], pred_dir_o};
        end
    end

    bpd_pht #(.ENTRIES(G_ENTRIES), .CNT_W(GCNT_W)) u_gshare (
        .clock    (clock),
        .rd_idx   (gsh_rd_idx),
        .rd_pred  (gpred),
        .upd_en   (do_rt),
        .upd_idx  (gsh_upd_idx),
        .upd_up   (rt_dir_i),
        .init_en  (init_g),
        .init_idx (init_cnt[GHR_W-1:0])
    );

    bpd_pht #(.ENTRIES(L_ENTRIES), .CNT_W(LCNT_W)) u_local (
        .clock    (clock),
        .rd_idx   (pred_lochist_i),
        .rd_pred  (lpred),
        .upd_en   (do_rt),
        .upd_idx  (rt_lochist_i),
        .upd_up   (rt_dir_i),
        .init_en  (init_l),
        .init_idx (init_cnt[LHIST_W-1:0])
    );

    bpd_pht #(.ENTRIES(G_ENTRIES), .CNT_W(CCNT_W)) u_choice (
        .clock    (clock),
        .rd_idx   (pred_pc_idx),
        .rd_pred  (sel_g),
        .upd_en   (cho_upd_en),
        .upd_idx  (rt_pc_idx),
        .upd_up   (cho_up),
        .init_en  (init_g),
        .init_idx (init_cnt[GHR_W-1:0])
    );

endmodule

// File: tb/tb_bpd1.sv
// tb_bpd1: directed scoreboard bench for bpd1 with default parameters.
// Every accepted prediction has its expected {tag, dir, override, target}
// queued by the stimulus; the monitor pops and compares on each accept.
module tb_bpd1;

    localparam int LHIST_W = 10;
    localparam int TAG_W   = 3;

    logic               clock = 1'b0;
    logic               reset_n;
    logic               pred_valid_i;
    logic               pred_cond_i;
    logic [63:0]        pred_pc_i;
    logic [LHIST_W-1:0] pred_lochist_i;
    logic               btb_dir_i;
    logic [63:0]        pc_t_i;
    logic [63:0]        pc_nt_i;
    logic               pred_dir_o;
    logic [TAG_W-1:0]   pred_tag_o;
    logic               pred_stall_o;
    logic               override_o;
    logic [63:0]        override_pc_o;
    logic               rt_valid_i;
    logic               rt_dir_i;
    logic [63:0]        rt_pc_i;
    logic [LHIST_W-1:0] rt_lochist_i;
    logic               flush_i;
    logic [TAG_W-1:0]   flush_tag_i;
    logic               flush_dir_i;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic             dir;
        logic             ovr;
        logic [63:0]      ovpc;
        string            name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clock = ~clock;

    bpd1 dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .pred_valid_i   (pred_valid_i),
        .pred_cond_i    (pred_cond_i),
        .pred_pc_i      (pred_pc_i),
        .pred_lochist_i (pred_lochist_i),
        .btb_dir_i      (btb_dir_i),
        .pc_t_i         (pc_t_i),
        .pc_nt_i        (pc_nt_i),
        .pred_dir_o     (pred_dir_o),
        .pred_tag_o     (pred_tag_o),
        .pred_stall_o   (pred_stall_o),
        .override_o     (override_o),
        .override_pc_o  (override_pc_o),
        .rt_valid_i     (rt_valid_i),
        .rt_dir_i       (rt_dir_i),
        .rt_pc_i        (rt_pc_i),
        .rt_lochist_i   (rt_lochist_i),
        .flush_i        (flush_i),
        .flush_tag_i    (flush_tag_i),
        .flush_dir_i    (flush_dir_i)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: one expected entry per accepted prediction.
    always @(negedge clock) begin
        exp_t e;
        if (reset_n && pred_valid_i && pred_cond_i && !pred_stall_o && !flush_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("[TB] FAIL unexpected accept: got tag %0d, expected no accept", pred_tag_o);
            end else begin
                e = exp_q.pop_front();
                checkOutput({e.name, " tag"},      64'(pred_tag_o),    64'(e.tag));
                checkOutput({e.name, " dir"},      64'(pred_dir_o),    64'(e.dir));
                checkOutput({e.name, " override"}, 64'(override_o),    64'(e.ovr));
                checkOutput({e.name, " ovr_pc"},   override_pc_o,      e.ovpc);
            end
        end
    end

    // Issue one conditional prediction and queue its expected response.
    task automatic applyStimulus(input string name, input logic [63:0] pc,
                                 input logic [LHIST_W-1:0] lh, input logic btb,
                                 input logic exp_dir, input int exp_tag);
        exp_t e;
        pred_valid_i   = 1'b1;
        pred_cond_i    = 1'b1;
        pred_pc_i      = pc;
        pred_lochist_i = lh;
        btb_dir_i      = btb;
        pc_t_i         = pc + 64'h100;
        pc_nt_i        = pc + 64'h4;
        e.tag  = TAG_W'(exp_tag);
        e.dir  = exp_dir;
        e.ovr  = btb ^ exp_dir;
        e.ovpc = exp_dir ? pc + 64'h100 : pc + 64'h4;
        e.name = name;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        pred_valid_i = 1'b0;
    endtask

    task automatic retireOne(input logic [63:0] pc, input logic dir,
                             input logic [LHIST_W-1:0] lh);
        rt_valid_i   = 1'b1;
        rt_pc_i      = pc;
        rt_dir_i     = dir;
        rt_lochist_i = lh;
        @(posedge clock);
        #1;
        rt_valid_i = 1'b0;
    endtask

    task automatic holdReset(input string name);
        pred_valid_i = 1'b1;
        pred_cond_i  = 1'b1;
        btb_dir_i    = 1'b1;
        rt_valid_i   = 1'b0;
        flush_i      = 1'b0;
        reset_n      = 1'b0;
        @(negedge clock);
        checkOutput({name, " reset stall"},    64'(pred_stall_o), 64'd1);
        checkOutput({name, " reset dir"},      64'(pred_dir_o),   64'd0);
        checkOutput({name, " reset override"}, 64'(override_o),   64'd0);
        checkOutput({name, " reset tag"},      64'(pred_tag_o),   64'd0);
        checkOutput({name, " reset ghr"},      64'(dut.ghr),      64'd0);
        checkOutput({name, " reset count"},    64'(dut.count),    64'd0);
    endtask

    task automatic releaseAndSweep(input string name);
        int n;
        @(negedge clock);
        reset_n      = 1'b1;
        pred_valid_i = 1'b0;
        n = 0;
        while (pred_stall_o === 1'b1 && n < 5000) begin
            @(posedge clock);
            #1;
            n++;
        end
        checkOutput({name, " sweep cycles"}, 64'(n), 64'd4096);
    endtask

    initial begin
        reset_n        = 1'b0;
        pred_valid_i   = 1'b0;
        pred_cond_i    = 1'b0;
        pred_pc_i      = '0;
        pred_lochist_i = '0;
        btb_dir_i      = 1'b0;
        pc_t_i         = '0;
        pc_nt_i        = '0;
        rt_valid_i     = 1'b0;
        rt_dir_i       = 1'b0;
        rt_pc_i        = '0;
        rt_lochist_i   = '0;
        flush_i        = 1'b0;
        flush_tag_i    = '0;
        flush_dir_i    = 1'b0;

        // Group 1: fill the checkpoint queue, stall, one retire frees a slot.
        holdReset("r1");
        releaseAndSweep("r1");
        for (int i = 0; i < 8; i++) begin
            applyStimulus($sformatf("fill%0d", i), 64'h1000 + 64'(16 * i), 10'h000,
                          (i % 2) == 1, 1'b0, i);
        end
        pred_valid_i = 1'b1;
        pred_cond_i  = 1'b1;
        btb_dir_i    = 1'b1;
        pred_pc_i    = 64'h2000;
        @(negedge clock);
        checkOutput("full stall",          64'(pred_stall_o), 64'd1);
        checkOutput("full override gated", 64'(override_o),   64'd0);
        checkOutput("full tag wrapped",    64'(pred_tag_o),   64'd0);
        checkOutput("full count",          64'(dut.count),    64'd8);
        @(posedge clock);
        #1;
        pred_valid_i = 1'b0;
        retireOne(64'h1000, 1'b0, 10'h000);
        @(negedge clock);
        checkOutput("stall after retire", 64'(pred_stall_o), 64'd0);
        applyStimulus("after retire", 64'h2000, 10'h000, 1'b1, 1'b0, 0);
        @(negedge clock);
        checkOutput("refilled stall", 64'(pred_stall_o), 64'd1);

        // Group 2: reset during the sweep, then flush recovery.
        holdReset("r2");
        @(negedge clock);
        reset_n      = 1'b1;
        pred_valid_i = 1'b0;
        repeat (100) @(posedge clock);
        #1;
        holdReset("r2 mid");
        releaseAndSweep("r2");
        for (int i = 0; i < 5; i++) begin
            applyStimulus($sformatf("pre flush%0d", i), 64'h3000 + 64'(16 * i), 10'h000,
                          1'b0, 1'b0, i);
        end
        flush_i     = 1'b1;
        flush_tag_i = 3'd2;
        flush_dir_i = 1'b1;
        @(posedge clock);
        #1;
        flush_i = 1'b0;
        checkOutput("flush ghr",   64'(dut.ghr),   64'h001);
        checkOutput("flush count", 64'(dut.count), 64'd3);
        applyStimulus("post flush", 64'h3100, 10'h000, 1'b1, 1'b0, 3);
        checkOutput("post flush ghr", 64'(dut.ghr), 64'h002);
        retireOne(64'h3000, 1'b0, 10'h000);
        retireOne(64'h3010, 1'b0, 10'h000);
        retireOne(64'h3020, 1'b0, 10'h000);
        checkOutput("three retires count", 64'(dut.count), 64'd1);
        rt_valid_i   = 1'b1;
        rt_pc_i      = 64'h3100;
        rt_dir_i     = 1'b0;
        rt_lochist_i = 10'h000;
        flush_i      = 1'b1;
        flush_tag_i  = 3'd3;
        flush_dir_i  = 1'b1;
        @(posedge clock);
        #1;
        rt_valid_i = 1'b0;
        flush_i    = 1'b0;
        checkOutput("retire+flush count", 64'(dut.count), 64'd0);
        checkOutput("retire+flush ghr",   64'(dut.ghr),   64'h003);
        retireOne(64'h3100, 1'b0, 10'h000);
        checkOutput("empty retire count", 64'(dut.count), 64'd0);
        applyStimulus("after empty retire", 64'h3200, 10'h000, 1'b0, 1'b0, 4);

        // Group 3: training of gshare, local and choice counters.
        holdReset("r3");
        releaseAndSweep("r3");
        for (int i = 0; i < 4; i++) begin
            applyStimulus($sformatf("train a%0d", i), 64'h1000, 10'h0AA, 1'b0, 1'b0, i);
        end
        for (int i = 0; i < 4; i++) begin
            retireOne(64'h1000, 1'b1, 10'h0AA);
        end
        applyStimulus("disagree0", 64'h1000, 10'h155, 1'b1, 1'b0, 4);
        applyStimulus("disagree1", 64'h1000, 10'h155, 1'b1, 1'b0, 5);
        retireOne(64'h1000, 1'b1, 10'h155);
        retireOne(64'h1000, 1'b1, 10'h155);
        applyStimulus("global taken",  64'h1000, 10'h033, 1'b0, 1'b1, 6);
        applyStimulus("local taken",   64'h3000, 10'h0AA, 1'b1, 1'b1, 7);
        applyStimulus("ghr reindexed", 64'h1000, 10'h033, 1'b1, 1'b0, 0);
        checkOutput("final ghr", 64'(dut.ghr), 64'h006);

        repeat (2) @(posedge clock);
        #1;
        checkOutput("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/bpd1.md
# bpd1

Parametrised tournament branch direction predictor for the fetch F1 stage, successor to the fixed-size bpd0. It holds its gshare, local and choice tables internally, and keeps a speculative global history register (GHR) with an in-order checkpoint queue for exact recovery on flush. It trains at retire and initialises its tables with a post-reset sweep. It drives the same override path as bpd0.

## Interface
- GHR_W, 12, global history width; gshare and choice tables have 2^GHR_W entries
- LHIST_W, 10, local history width; local table has 2^LHIST_W entries
- GCNT_W, 2, gshare counter width
- LCNT_W, 3, local counter width
- CCNT_W, 2, choice counter width
- CKPT_DEPTH, 8, checkpoint queue depth; power of two, at least 2
- TAG_W, $clog2(CKPT_DEPTH), derived checkpoint tag width

Ports:
- clock  in  1  single clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- pred_valid_i  in  1  fetch slot valid in F1
- pred_cond_i  in  1  slot is a conditional branch
- pred_pc_i  in  64  branch PC
- pred_lochist_i  in  LHIST_W  local history for this PC
- btb_dir_i  in  1  BTB direction
- pc_t_i, pc_nt_i  in  64 each  taken and not-taken targets
- pred_dir_o  out  1  final direction
- pred_tag_o  out  TAG_W  checkpoint tag allocated to this branch
- pred_stall_o  out  1  predictor cannot accept a conditional branch
- override_o  out  1  redirect F1
- override_pc_o  out  64  redirect target
- rt_valid_i  in  1  oldest checkpointed branch retires
- rt_dir_i  in  1  resolved direction
- rt_pc_i  in  64  retiring PC
- rt_lochist_i  in  LHIST_W  local history used at prediction
- flush_i  in  1  mispredict recovery
- flush_tag_i  in  TAG_W  tag of the mispredicted branch
- flush_dir_i  in  1  correct direction of the mispredicted branch

## Operation
- Table indices: gshare index = pred_pc_i[GHR_W+1:2] ^ ghr. Choice index = pred_pc_i[GHR_W+1:2]. Local index = pred_lochist_i.
- A prediction bit is the counter MSB. Choice MSB = 1 selects global; otherwise local.
- pred_dir_o is the selected prediction. override_pc_o = pred_dir_o ? pc_t_i : pc_nt_i.
- override_o = pred_valid_i & pred_cond_i & ~pred_stall_o & ~flush_i & (btb_dir_i ^ pred_dir_o).
- Accept = pred_valid_i & pred_cond_i & ~pred_stall_o & ~flush_i. On accept:
  - push {ghr, gpred, lpred} at the tail;
  - pred_tag_o = tail index;
  - ghr <= {ghr[GHR_W-2:0], pred_dir_o}.
- Retire, when the queue is not empty:
  - pop the head entry;
  - gshare and local counters saturate toward rt_dir_i; the gshare write index uses rt_pc_i and the head ghr;
  - if head gpred ≠ lpred, the choice counter increments when gpred == rt_dir_i, else decrements;
  - retire on an empty queue is ignored.
- Flush:
  - ghr <= {ckpt[flush_tag_i].ghr[GHR_W-2:0], flush_dir_i};
  - tail <= flush_tag_i + 1; entries younger than the tag are discarded, the flushed branch stays;
  - count is recomputed modulo CKPT_DEPTH.
- Counters: saturating; no wrap at 0 or at the maximum.
- Init values: gshare and local = 2^(W-1)-1 (weakly not-taken); choice = 2^(CCNT_W-1)-1 (weakly local).

## Timing
- Reset values:
  - ghr = 0; head = tail = count = 0;
  - init counter = 0, busy = 1;
  - pred_dir_o = 0, override_o = 0, pred_stall_o = 1.
- Init sweep: one entry of every table written per cycle. Busy for 2^max(GHR_W,LHIST_W) cycles after reset deasserts. Indices beyond a table's size are not written.
- While busy: pred_stall_o = 1, retire and flush are ignored, pred_dir_o = 0.
- pred_stall_o = busy | (count == CKPT_DEPTH).
- Prediction is combinational in the F1 cycle. GHR, queue and table updates take effect at the next edge.
- Table read during a same-cycle write returns the old value.
- Retire and flush in the same cycle: the pop is applied first, then the truncation. Flush of the head tag with retire of that head leaves count = 0.
- Pointers wrap modulo CKPT_DEPTH.
- A reset assertion mid-sweep or mid-operation restarts the sweep from index 0.

## Structure
- Shared package bpd_pkg holds:
  - the checkpoint entry struct {ghr, gpred, lpred};
  - the counter-init function;
  - the saturating increment/decrement function.
- One sub-module, bpd_pht: a parametrised counter table (ENTRIES, CNT_W) with one read port, one update port and an init-write port. It is instantiated three times.

## Test plan
- Release reset with default parameters → pred_stall_o = 1 for exactly 4096 cycles. The first prediction is then not-taken, and pred_tag_o = 0.
- Push 8 conditional predictions with no retire → pred_stall_o = 1 and the 9th is not accepted. One retire → stall drops the next cycle.
- Predict tags 0–4, then flush tag 2 with flush_dir_i = 1 → ghr = {ckpt2.ghr[10:0], 1}, the next tag is 3, and count = 3.
- Retire PC 0x1000 taken 4 times with constant history → the gshare counter saturates at 3, and the prediction for that index is taken.
- Retire with gpred = 1, lpred = 0, rt_dir_i = 1 twice → the choice counter goes 1 to 3, and pred_dir_o follows global.
- Same-cycle retire of the head plus flush of the head tag → count = 0, and ghr is restored from the head entry.
